// File: rtl/router_pkg.sv
// Shared constants for the gold_router datapath.
// Packet field positions and requester indices.
package router_pkg;
  localparam int PACKET_SIZE = 64;
  localparam int VC_BIT      = 63;
  localparam int DIR_BIT     = 62;
  localparam int HOP_MSB     = 55;
  localparam int HOP_LSB     = 48;
  localparam int IDX_CW      = 0;
  localparam int IDX_CCW     = 1;
  localparam int IDX_PE      = 2;
endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin select.
// Scans req upward from ptr, wrapping 2 to 0.
module rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);
  always_comb begin
    gnt = 3'b000;
    case (ptr)
      2'd1: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end
endmodule

// File: rtl/ring_port_arbiter.sv
// Output-channel arbiter: fills VC == polarity,
// drains VC == ~polarity onto the link.
module ring_port_arbiter
  import router_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   polarity,
  input  logic [2:0]             req_vc0,
  input  logic [2:0]             req_vc1,
  input  logic [PACKET_SIZE-1:0] din_cw,
  input  logic [PACKET_SIZE-1:0] din_ccw,
  input  logic [PACKET_SIZE-1:0] din_pe,
  output logic [2:0]             gnt,
  output logic                   so,
  input  logic                   ro,
  output logic [PACKET_SIZE-1:0] dout
);
  logic [1:0]             r_full;
  logic [PACKET_SIZE-1:0] r_data [2];
  logic [1:0]             r_rr   [2];

  logic [2:0]             w_req0;
  logic [2:0]             w_req1;
  logic [2:0]             w_gnt0;
  logic [2:0]             w_gnt1;
  logic [2:0]             w_gnt;
  logic [PACKET_SIZE-1:0] w_din;
  logic [1:0]             w_rr_nxt;

  // A full buffer blocks only its own VC's grants.
  assign w_req0 = req_vc0 & {3{~r_full[0]}};
  assign w_req1 = req_vc1 & {3{~r_full[1]}};

  rr_arb3 u_arb0 (.req(w_req0), .ptr(r_rr[0]), .gnt(w_gnt0));
  rr_arb3 u_arb1 (.req(w_req1), .ptr(r_rr[1]), .gnt(w_gnt1));

  assign w_gnt = reset ? 3'b000 : (polarity ? w_gnt1 : w_gnt0);
  assign gnt   = w_gnt;
  assign so    = r_full[~polarity];
  assign dout  = r_data[~polarity];

  always_comb begin
    w_din    = '0;
    w_rr_nxt = 2'd0;
    unique case (1'b1)
      w_gnt[IDX_CW]: begin
        w_din    = din_cw;
        w_rr_nxt = 2'd1;
      end
      w_gnt[IDX_CCW]: begin
        w_din    = din_ccw;
        w_rr_nxt = 2'd2;
      end
      w_gnt[IDX_PE]: begin
        w_din    = din_pe;
        w_rr_nxt = 2'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full    <= 2'b00;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_rr[0]   <= 2'd0;
      r_rr[1]   <= 2'd0;
    end else begin
      if (|w_gnt) begin
        r_full[polarity] <= 1'b1;
        r_data[polarity] <= w_din;
        r_rr[polarity]   <= w_rr_nxt;
      end
      // Drain clears only the flag; data stays visible.
      if (so && ro)
        r_full[~polarity] <= 1'b0;
    end
  end

  a_vc_match : assert property (
    @(posedge clk) disable iff (reset)
    (|w_gnt) |-> (w_din[VC_BIT] == polarity)
  );
endmodule

// File: tb/tb_ring_port_arbiter.sv
// Directed-vector bench for ring_port_arbiter.
module tb_ring_port_arbiter;
  import router_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   pol;
  logic [2:0]             req_vc0;
  logic [2:0]             req_vc1;
  logic [PACKET_SIZE-1:0] din_cw;
  logic [PACKET_SIZE-1:0] din_ccw;
  logic [PACKET_SIZE-1:0] din_pe;
  logic [2:0]             gnt;
  logic                   so;
  logic                   ro;
  logic [PACKET_SIZE-1:0] dout;
  logic [7:0]             tag;

  int checks = 0;
  int errors = 0;

  ring_port_arbiter dut (
    .clk(clk), .reset(reset), .polarity(pol),
    .req_vc0(req_vc0), .req_vc1(req_vc1),
    .din_cw(din_cw), .din_ccw(din_ccw), .din_pe(din_pe),
    .gnt(gnt), .so(so), .ro(ro), .dout(dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) pol <= 1'b0;
    else       pol <= ~pol;

  function automatic logic [63:0] pk(logic vc, int src, logic [7:0] t);
    return {vc, 1'b0, 6'd0, 8'(src), 40'd0, t};
  endfunction

  always_comb begin
    din_cw  = pk(pol, 0, tag);
    din_ccw = pk(pol, 1, tag);
    din_pe  = pk(pol, 2, tag);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  r0;
    logic [2:0]  r1;
    logic        ro;
    logic [7:0]  tag;
    logic [2:0]  g;
    logic        s;
    logic [63:0] d;
  } vec_t;

  vec_t vt [18];

  initial begin
    vt[0]  = '{3'b111, 3'b000, 1'b1, 8'h01, 3'b001, 1'b0, 64'd0};
    vt[1]  = '{3'b111, 3'b000, 1'b1, 8'h02, 3'b000, 1'b1, pk(0,0,8'h01)};
    vt[2]  = '{3'b111, 3'b000, 1'b1, 8'h03, 3'b010, 1'b0, 64'd0};
    vt[3]  = '{3'b111, 3'b000, 1'b1, 8'h04, 3'b000, 1'b1, pk(0,1,8'h03)};
    vt[4]  = '{3'b111, 3'b000, 1'b1, 8'h05, 3'b100, 1'b0, 64'd0};
    vt[5]  = '{3'b111, 3'b000, 1'b1, 8'h06, 3'b000, 1'b1, pk(0,2,8'h05)};
    vt[6]  = '{3'b111, 3'b000, 1'b1, 8'h07, 3'b001, 1'b0, 64'd0};
    vt[7]  = '{3'b111, 3'b010, 1'b0, 8'h08, 3'b010, 1'b1, pk(0,0,8'h07)};
    vt[8]  = '{3'b111, 3'b010, 1'b1, 8'h09, 3'b000, 1'b1, pk(1,1,8'h08)};
    vt[9]  = '{3'b111, 3'b010, 1'b0, 8'h0A, 3'b010, 1'b1, pk(0,0,8'h07)};
    vt[10] = '{3'b111, 3'b000, 1'b1, 8'h0B, 3'b000, 1'b1, pk(1,1,8'h0A)};
    vt[11] = '{3'b111, 3'b000, 1'b1, 8'h0C, 3'b000, 1'b1, pk(0,0,8'h07)};
    vt[12] = '{3'b111, 3'b000, 1'b1, 8'h0D, 3'b010, 1'b0, pk(1,1,8'h0A)};
    vt[13] = '{3'b000, 3'b000, 1'b1, 8'h0E, 3'b000, 1'b1, pk(0,1,8'h0D)};
    vt[14] = '{3'b100, 3'b000, 1'b1, 8'h0F, 3'b100, 1'b0, pk(1,1,8'h0A)};
    vt[15] = '{3'b000, 3'b000, 1'b1, 8'h10, 3'b000, 1'b1, pk(0,2,8'h0F)};
    vt[16] = '{3'b000, 3'b000, 1'b1, 8'h11, 3'b000, 1'b0, pk(1,1,8'h0A)};
    vt[17] = '{3'b000, 3'b000, 1'b1, 8'h12, 3'b000, 1'b0, pk(0,2,8'h0F)};

    reset   = 1'b1;
    req_vc0 = 3'b111;
    req_vc1 = 3'b000;
    ro      = 1'b1;
    tag     = 8'h00;
    @(negedge clk);
    chk("rst_gnt",  64'(gnt),  64'd0);
    chk("rst_so",   64'(so),   64'd0);
    chk("rst_dout", dout,      64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int k = 0; k < 18; k++) begin
      req_vc0 = vt[k].r0;
      req_vc1 = vt[k].r1;
      ro      = vt[k].ro;
      tag     = vt[k].tag;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", k),  64'(gnt), 64'(vt[k].g));
      chk($sformatf("v%0d_so", k),   64'(so),  64'(vt[k].s));
      chk($sformatf("v%0d_dout", k), dout,     vt[k].d);
      @(posedge clk); #1;
    end

    // Fill both buffers under backpressure, then pulse reset mid-cycle.
    req_vc0 = 3'b001; req_vc1 = 3'b000; ro = 1'b0; tag = 8'h20;
    @(negedge clk);
    chk("fill0_gnt", 64'(gnt), 64'(3'b001));
    @(posedge clk); #1;
    req_vc0 = 3'b000; req_vc1 = 3'b010; tag = 8'h21;
    @(negedge clk);
    chk("fill1_gnt", 64'(gnt), 64'(3'b010));
    chk("fill1_so",  64'(so),  64'd1);
    @(posedge clk); #1;
    req_vc1 = 3'b000; tag = 8'h22;
    @(negedge clk);
    chk("full_so",   64'(so), 64'd1);
    chk("full_dout", dout,    pk(1,1,8'h21));
    #1 reset = 1'b1;
    #1;
    chk("arst_so",   64'(so),  64'd0);
    chk("arst_dout", dout,     64'd0);
    chk("arst_gnt",  64'(gnt), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    req_vc0 = 3'b111; req_vc1 = 3'b111; ro = 1'b1; tag = 8'h23;
    @(negedge clk);
    chk("post_rr1_gnt", 64'(gnt), 64'(3'b001));
    chk("post_so",      64'(so),  64'd0);
    @(posedge clk); #1;
    tag = 8'h24;
    @(negedge clk);
    chk("post_rr0_gnt", 64'(gnt), 64'(3'b001));
    chk("post_dout",    dout,     pk(1,0,8'h23));
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
